ingress_commit_fifo: RTL and testbench
======================================

Name: ingress_commit_fifo

Overview:
- Upstream neighbour of the ingress FSM in the CVA6 trace-encoder connector.
- Captures up to NRET retiring-instruction entries per cycle from the CVA6 commit ports and buffers them in program order in a circular buffer.
- Presents exactly one mure_pkg::fifo_entry_s per cycle to the FSM.
- CVA6 cannot be stalled, so there is no backpressure. Overflow is detected, whole commit groups are dropped, and a sticky flag is raised.

Parameters:
- NRET, 2, number of commit ports sampled per cycle; port 0 is oldest.
- DEPTH, 16, buffer entries; power of two, DEPTH >= NRET.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- entries_i  in  NRET x mure_pkg::fifo_entry_s  commit-port entries; each slot's .valid marks a retirement
- clear_overflow_i  in  1  clears overflow_o
- fifo_entry_o  out  mure_pkg::fifo_entry_s  head entry to the ingress FSM
- count_o  out  $clog2(DEPTH)+1  current occupancy
- full_o  out  1  count_o == DEPTH
- overflow_o  out  1  sticky: a commit group was dropped

Behaviour:
- Reset (async, rst_ni low):
  - read pointer, write pointer and count = 0.
  - overflow_o = 0; fifo_entry_o = all zeros.
  - Storage contents need not be cleared.
- Push:
  - n_in = number of entries_i[k].valid set.
  - Valid slots are compacted in ascending port index and written to wr_ptr, wr_ptr+1, ... (mod DEPTH).
  - wr_ptr advances by n_in.
  - Invalid slots are ignored, including when they sit between valid slots.
- Space check:
  - A group is accepted only if n_in <= DEPTH - count, where count is the value before this cycle's pop.
  - Accepted: all n_in entries are written. Rejected: none are written, wr_ptr is unchanged, and overflow_o is set on the next edge.
  - Groups are never partially written.
- Pop:
  - Whenever count > 0, the head is consumed every cycle unconditionally; rd_ptr advances by 1.
- Output:
  - fifo_entry_o is combinational from storage[rd_ptr] when count > 0, with .valid forced to 1.
  - When count == 0, fifo_entry_o is driven all-zero. This is required because the downstream FSM decodes itype without qualifying on valid.
- Latency: an entry pushed in cycle N is visible on fifo_entry_o in cycle N+1 at the earliest. There is no same-cycle bypass.
- Occupancy: count_next = count + (accepted ? n_in : 0) - (count > 0 ? 1 : 0). Simultaneous push and pop is legal.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. A group of NRET may straddle the DEPTH-1 -> 0 boundary.
- overflow_o:
  - Set wins over clear when a rejection and clear_overflow_i coincide.
  - Otherwise clear_overflow_i drops it to 0 on the next edge.
- Ordering: output order equals port order within a cycle, and cycle order across cycles.
- Reset asserted mid-operation: all buffered entries are discarded immediately; fifo_entry_o = 0 in the same cycle.

Optional Feature:
- Macro: INGRESS_DROP_CNT_EN.
- When defined:
  - Adds output port dropped_cnt_o, 16 bits.
  - Counts individual dropped entries: it adds n_in of each rejected group and saturates at 16'hFFFF.
  - Resets to 0 and is cleared together with overflow_o by clear_overflow_i. Increment wins over clear when both occur in the same cycle.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Single push: port0 valid, pc=0x80000000, compressed=1 in cycle 0 -> fifo_entry_o.valid=1, pc=0x80000000 in cycle 1; count_o returns to 0 in cycle 2; fifo_entry_o all-zero in cycle 2.
- Dual push with gap: port0 invalid, port1 valid (pc=0x100) in cycle 0, then port0+port1 valid (0x104, 0x108) in cycle 1 -> outputs 0x100, 0x104, 0x108 in cycles 1, 2, 3, with no bubbles.
- Fill/overflow: push 2 entries/cycle for 16 cycles (DEPTH=16) -> count_o rises by 1 per cycle. Once count_o >= 15 at group arrival, groups are rejected and overflow_o=1. After inputs stop, output order matches accepted entries only, with no partial group. With INGRESS_DROP_CNT_EN, dropped_cnt_o equals the total rejected entries.
- Wrap-around: preload so wr_ptr=15, then push 2 entries (pc 0xA0, 0xA4) -> stored at slots 15 and 0; emitted in order 0xA0, 0xA4.
- Overflow clear race: rejection and clear_overflow_i in the same cycle -> overflow_o=1. clear_overflow_i alone in the next cycle -> overflow_o=0.
- Reset mid-operation: count_o=5, then rst_ni low for 1 cycle -> fifo_entry_o=0, count_o=0 and overflow_o=0 immediately. After release, the first new push is emitted correctly from slot 0.

Source files
------------

// File: rtl/ingress_commit_fifo.sv
// Commit-port capture FIFO feeding the trace-encoder ingress FSM; no backpressure, whole groups dropped on overflow.
// Optional dropped-entry counter enabled by defining INGRESS_DROP_CNT_EN.

package mure_pkg;
  typedef struct packed {
    logic        valid;
    logic [2:0]  itype;
    logic [1:0]  priv;
    logic        compressed;
    logic [63:0] pc;
  } fifo_entry_s;
endpackage

module ingress_commit_fifo #(
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  mure_pkg::fifo_entry_s [NRET-1:0] entries_i,
  input  logic                            clear_overflow_i,
  output mure_pkg::fifo_entry_s           fifo_entry_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic                            full_o,
  output logic                            overflow_o
`ifdef INGRESS_DROP_CNT_EN
  ,
  output logic [15:0]                     dropped_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]         r_rdPtr;
  logic [PW-1:0]         r_wrPtr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  mure_pkg::fifo_entry_s r_mem [DEPTH];

  logic [CW-1:0] w_slotOfs [NRET];
  logic [PW-1:0] w_wrIdx   [NRET];
  logic [CW-1:0] w_nIn;
  logic [CW-1:0] w_space;
  logic [CW-1:0] w_countNext;
  logic          w_accept;
  logic          w_pop;

  // Each valid slot lands at wr_ptr plus the number of valid slots below it.
  always_comb begin
    w_nIn = '0;
    for (int k = 0; k < NRET; k++) begin
      w_slotOfs[k] = w_nIn;
      w_wrIdx[k]   = r_wrPtr + w_slotOfs[k][PW-1:0];
      if (entries_i[k].valid) w_nIn = w_nIn + CW'(1);
    end
  end

  assign w_space     = CW'(DEPTH) - r_count;
  assign w_accept    = (w_nIn <= w_space);
  assign w_pop       = (r_count != '0);
  assign w_countNext = r_count + (w_accept ? w_nIn : '0) - (w_pop ? CW'(1) : '0);

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      for (int k = 0; k < NRET; k++) begin
        if (entries_i[k].valid) r_mem[w_wrIdx[k]] <= entries_i[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wrPtr <= r_wrPtr + w_nIn[PW-1:0];
      if (w_pop)    r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= w_countNext;
      if (!w_accept)             r_overflow <= 1'b1;
      else if (clear_overflow_i) r_overflow <= 1'b0;
    end
  end

  // Downstream decodes itype without looking at valid, so an empty FIFO must drive zeros.
  always_comb begin
    fifo_entry_o = '0;
    if (w_pop) begin
      fifo_entry_o       = r_mem[r_rdPtr];
      fifo_entry_o.valid = 1'b1;
    end
  end

  assign count_o    = r_count;
  assign full_o     = (r_count == CW'(DEPTH));
  assign overflow_o = r_overflow;

`ifdef INGRESS_DROP_CNT_EN
  logic [15:0] r_droppedCnt;
  logic [16:0] w_dropSum;

  assign w_dropSum = {1'b0, r_droppedCnt} + 17'(w_nIn);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_droppedCnt <= '0;
    end else if (!w_accept) begin
      r_droppedCnt <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
    end else if (clear_overflow_i) begin
      r_droppedCnt <= '0;
    end
  end

  assign dropped_cnt_o = r_droppedCnt;
`endif

endmodule

// File: tb/tb_ingress_commit_fifo.sv
// Scoreboard bench for ingress_commit_fifo: a queue model of accepted entries predicts head, occupancy and overflow.
// Checks the dropped-entry counter too when INGRESS_DROP_CNT_EN is defined.

module tb_ingress_commit_fifo;

  typedef mure_pkg::fifo_entry_s entry_t;

  logic                clk;
  logic                rstN;
  entry_t [1:0]        entries;
  logic                clearOvf;
  entry_t              dout;
  logic [4:0]          count;
  logic                full;
  logic                ovf;
`ifdef INGRESS_DROP_CNT_EN
  logic [15:0]         dropCnt;
`endif

  entry_t q[$];
  logic   mOvf;
  int     mDrop;
  int     checks;
  int     failures;

  ingress_commit_fifo #(.NRET(2), .DEPTH(16)) dut (
    .clk_i            (clk),
    .rst_ni           (rstN),
    .entries_i        (entries),
    .clear_overflow_i (clearOvf),
    .fifo_entry_o     (dout),
    .count_o          (count),
    .full_o           (full),
    .overflow_o       (ovf)
`ifdef INGRESS_DROP_CNT_EN
    ,
    .dropped_cnt_o    (dropCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic entry_t mk(input logic [63:0] pc, input logic c);
    entry_t e;
    e            = '0;
    e.valid      = 1'b1;
    e.pc         = pc;
    e.compressed = c;
    e.itype      = pc[4:2];
    e.priv       = pc[6:5];
    return e;
  endfunction

  function automatic entry_t mkInv(input logic [63:0] pc);
    entry_t e;
    e       = mk(pc, 1'b1);
    e.valid = 1'b0;
    return e;
  endfunction

  function automatic entry_t expHead();
    entry_t e;
    e = '0;
    if (q.size() > 0) begin
      e       = q[0];
      e.valid = 1'b1;
    end
    return e;
  endfunction

  // Drives one cycle of stimulus and advances the model at the same edge the DUT sees.
  task automatic step(input entry_t e0, input entry_t e1, input logic clr);
    int  n;
    int  sz;
    bit  rej;
    entries[0] = e0;
    entries[1] = e1;
    clearOvf   = clr;
    n = int'(e0.valid) + int'(e1.valid);
    @(posedge clk);
    sz  = q.size();
    rej = (n > 16 - sz);
    if (sz > 0) void'(q.pop_front());
    if (!rej) begin
      if (e0.valid) q.push_back(e0);
      if (e1.valid) q.push_back(e1);
      if (clr) begin
        mOvf  = 1'b0;
        mDrop = 0;
      end
    end else begin
      mOvf  = 1'b1;
      mDrop = (mDrop + n > 65535) ? 65535 : mDrop + n;
    end
    #1;
  endtask

  task automatic modelReset();
    q.delete();
    mOvf  = 1'b0;
    mDrop = 0;
  endtask

  task automatic test_reset();
    rstN     = 1'b1;
    entries  = '0;
    clearOvf = 1'b0;
    modelReset();
    #1 rstN = 1'b0;
    #2;
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (dout !== '0) begin failures++; $display("[TB] FAIL reset_entry: got %h expected 0", dout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  task automatic test_single();
    step(mk(64'h8000_0000, 1'b1), '0, 1'b0);
    checks++; if (dout.valid !== 1'b1 || dout.pc !== 64'h8000_0000 || dout.compressed !== 1'b1)
      begin failures++; $display("[TB] FAIL single_head: got %h expected pc 80000000 valid 1 compressed 1", dout); end
    checks++; if (dout !== expHead()) begin failures++; $display("[TB] FAIL single_sb: got %h expected %h", dout, expHead()); end
    checks++; if (count !== 5'd1) begin failures++; $display("[TB] FAIL single_count1: got %0d expected 1", count); end
    step('0, '0, 1'b0);
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL single_count2: got %0d expected 0", count); end
    checks++; if (dout !== '0) begin failures++; $display("[TB] FAIL single_empty: got %h expected 0", dout); end
  endtask

  task automatic test_dual_gap();
    logic [63:0] expPc [3];
    expPc[0] = 64'h100; expPc[1] = 64'h104; expPc[2] = 64'h108;
    step(mkInv(64'hDEAD), mk(64'h100, 1'b0), 1'b0);
    checks++; if (dout.pc !== expPc[0] || dout !== expHead()) begin failures++; $display("[TB] FAIL gap_c1: got %h expected pc %h", dout, expPc[0]); end
    step(mk(64'h104, 1'b0), mk(64'h108, 1'b1), 1'b0);
    checks++; if (dout.pc !== expPc[1] || dout !== expHead()) begin failures++; $display("[TB] FAIL gap_c2: got %h expected pc %h", dout, expPc[1]); end
    checks++; if (count !== 5'd2) begin failures++; $display("[TB] FAIL gap_count: got %0d expected 2", count); end
    step('0, '0, 1'b0);
    checks++; if (dout.pc !== expPc[2] || dout !== expHead()) begin failures++; $display("[TB] FAIL gap_c3: got %h expected pc %h", dout, expPc[2]); end
    step('0, '0, 1'b0);
    checks++; if (count !== 5'd0 || dout !== '0) begin failures++; $display("[TB] FAIL gap_empty: got count %0d entry %h expected 0", count, dout); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(mk(64'h1000 + 64'(16 * i), 1'b0), mk(64'h1008 + 64'(16 * i), 1'b1), 1'b0);
      checks++; if (count !== 5'(q.size())) begin failures++; $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, count, q.size()); end
      checks++; if (ovf !== mOvf) begin failures++; $display("[TB] FAIL fill_ovf[%0d]: got %b expected %b", i, ovf, mOvf); end
      checks++; if (full !== (q.size() == 16)) begin failures++; $display("[TB] FAIL fill_full[%0d]: got %b", i, full); end
      if (i < 14) begin
        checks++; if (count !== 5'(i + 2)) begin failures++; $display("[TB] FAIL fill_ramp[%0d]: got %0d expected %0d", i, count, i + 2); end
      end
    end
    checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL fill_ovf_final: got %b expected 1", ovf); end
`ifdef INGRESS_DROP_CNT_EN
    checks++; if (dropCnt !== 16'd2) begin failures++; $display("[TB] FAIL fill_drop: got %0d expected 2", dropCnt); end
`endif
  endtask

  task automatic test_clear_race();
    bit found;
    found = 1'b0;
    step('0, '0, 1'b1);
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL clear_alone: got %b expected 0", ovf); end
`ifdef INGRESS_DROP_CNT_EN
    checks++; if (dropCnt !== 16'd0) begin failures++; $display("[TB] FAIL clear_drop: got %0d expected 0", dropCnt); end
`endif
    for (int i = 0; i < 8 && !found; i++) begin
      if (2 > 16 - q.size()) begin
        found = 1'b1;
        step(mk(64'h3000 + 64'(16 * i), 1'b0), mk(64'h3008 + 64'(16 * i), 1'b0), 1'b1);
        checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL race_set_wins: got %b expected 1", ovf); end
`ifdef INGRESS_DROP_CNT_EN
        checks++; if (dropCnt !== 16'(mDrop)) begin failures++; $display("[TB] FAIL race_drop: got %0d expected %0d", dropCnt, mDrop); end
`endif
        step('0, '0, 1'b1);
        checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL race_clear: got %b expected 0", ovf); end
`ifdef INGRESS_DROP_CNT_EN
        checks++; if (dropCnt !== 16'd0) begin failures++; $display("[TB] FAIL race_drop_clear: got %0d expected 0", dropCnt); end
`endif
      end else begin
        step(mk(64'h3000 + 64'(16 * i), 1'b0), mk(64'h3008 + 64'(16 * i), 1'b0), 1'b0);
      end
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL race_setup: got no rejection expected one within 8 cycles"); end
  endtask

  task automatic test_drain();
    int budget;
    logic [63:0] lastPc;
    budget = 0;
    lastPc = '0;
    while (q.size() > 0 && budget < 40) begin
      checks++; if (dout !== expHead()) begin failures++; $display("[TB] FAIL drain_head: got %h expected %h", dout, expHead()); end
      checks++; if (dout.pc <= lastPc) begin failures++; $display("[TB] FAIL drain_order: got %h expected above %h", dout.pc, lastPc); end
      lastPc = dout.pc;
      step('0, '0, 1'b0);
      budget++;
    end
    checks++; if (q.size() != 0) begin failures++; $display("[TB] FAIL drain_timeout: got %0d left expected 0", q.size()); end
    checks++; if (count !== 5'd0 || dout !== '0) begin failures++; $display("[TB] FAIL drain_empty: got count %0d entry %h expected 0", count, dout); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(mk(64'h4000 + 64'(16 * i), 1'b0), mk(64'h4008 + 64'(16 * i), 1'b0), 1'b0);
    checks++; if (count !== 5'd5) begin failures++; $display("[TB] FAIL mid_pre_count: got %0d expected 5", count); end
    entries  = '0;
    clearOvf = 1'b0;
    rstN     = 1'b0;
    modelReset();
    #2;
    checks++; if (dout !== '0) begin failures++; $display("[TB] FAIL mid_entry: got %h expected 0", dout); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL mid_count: got %0d expected 0", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL mid_ovf: got %b expected 0", ovf); end
    @(posedge clk);
    #1 rstN = 1'b1;
    step(mk(64'h200, 1'b1), '0, 1'b0);
    checks++; if (dout.pc !== 64'h200 || dout !== expHead()) begin failures++; $display("[TB] FAIL mid_first: got %h expected pc 200", dout); end
    checks++; if (count !== 5'd1) begin failures++; $display("[TB] FAIL mid_first_count: got %0d expected 1", count); end
    step('0, '0, 1'b0);
  endtask

  task automatic test_wrap();
    rstN = 1'b0;
    modelReset();
    @(posedge clk);
    #1 rstN = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(mk(64'h5000 + 64'(4 * i), 1'b0), '0, 1'b0);
      checks++; if (dout !== expHead()) begin failures++; $display("[TB] FAIL wrap_pre[%0d]: got %h expected %h", i, dout, expHead()); end
    end
    step(mk(64'hA0, 1'b0), mk(64'hA4, 1'b1), 1'b0);
    checks++; if (dout.pc !== 64'hA0 || dout !== expHead()) begin failures++; $display("[TB] FAIL wrap_first: got %h expected pc a0", dout); end
    step('0, '0, 1'b0);
    checks++; if (dout.pc !== 64'hA4 || dout !== expHead()) begin failures++; $display("[TB] FAIL wrap_second: got %h expected pc a4", dout); end
    step('0, '0, 1'b0);
    checks++; if (count !== 5'd0 || dout !== '0) begin failures++; $display("[TB] FAIL wrap_empty: got count %0d entry %h expected 0", count, dout); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_dual_gap();
    test_fill();
    test_clear_race();
    test_drain();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
